// File: rtl/hdmi_axi_rd_master.sv
// ---------------------------------------------------------------------------
// hdmi_axi_rd_master
//
// Turns a line-fetch request from the address generator into a sequence of
// AXI4 INCR read bursts. Returned pixel beats are streamed into the HDMI line
// FIFO. Only one burst is outstanding at a time, and everything runs in the
// pixel clock domain.
//
// Ports:
//   clk_vga, rst_n            pixel clock, async active-low reset
//   kick, read_addr, read_num fetch request (sampled in IDLE only)
//   busy                      fetch in progress (registered)
//   m_axi_ar*                 AXI4 read address channel (master side)
//   m_axi_r*                  AXI4 read data channel (master side)
//   fifo_wr, fifo_wdata,      line FIFO write port; fifo_full must respond
//   fifo_full                 with zero-cycle latency
//   rd_err, rd_err_cnt        sticky error flag and saturating error count
//
// Optional feature macro: HDMI_AXI_RD_ERRCHK_EN
//   defined   : beats with rresp != OKAY, or with rlast disagreeing with the
//               internal beat counter, set rd_err and bump rd_err_cnt
//   undefined : rd_err / rd_err_cnt tied to 0, rresp / rlast unused
//
// State table:
//   state  | meaning
//   IDLE   | waiting for kick
//   ADDR   | AR request on the bus, waiting for arready
//   DATA   | receiving beats of the current burst
//   DONE   | one-cycle tail before returning to IDLE
// ---------------------------------------------------------------------------
module hdmi_axi_rd_master #(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 16,
    parameter int NUM_WIDTH  = 16
) (
    input  logic                  clk_vga,
    input  logic                  rst_n,

    input  logic                  kick,
    input  logic [31:0]           read_addr,
    input  logic [NUM_WIDTH-1:0]  read_num,
    output logic                  busy,

    output logic [31:0]           m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic                  fifo_wr,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    input  logic                  fifo_full,

    output logic                  rd_err,
    output logic [7:0]            rd_err_cnt
);

    localparam int          BYTES     = DATA_WIDTH / 8;
    localparam int          SZ        = $clog2(BYTES);
    localparam logic [8:0]  BL        = 9'(BURST_LEN);
    localparam logic [31:0] ADDR_MASK = ~32'(BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [31:0]            cur_addr;
    logic [NUM_WIDTH-1:0]   remain;
    logic [8:0]             beat_cnt;

    logic [12:0]            bnd_bytes;
    logic [12:0]            bnd_beats;
    logic [8:0]             cap;
    logic [8:0]             len;
    logic                   beat;
    logic                   last_cnt;
    logic                   burst_end;

    // Burst length: the smallest of the remaining beats, the burst limit and
    // the beats left before the next 4 KiB page. cur_addr and remain only move
    // at burst end, so len stays constant across ADDR and DATA of one burst.
    assign bnd_bytes = 13'h1000 - {1'b0, cur_addr[11:0]};
    assign bnd_beats = bnd_bytes >> SZ;
    assign cap       = (bnd_beats < 13'(BL)) ? bnd_beats[8:0] : BL;
    assign len       = (32'(remain) < 32'(cap)) ? 9'(remain) : cap;

    assign beat      = (state == S_DATA) && m_axi_rvalid && !fifo_full;
    assign last_cnt  = (beat_cnt == (len - 9'd1));
    assign burst_end = beat && last_cnt;

    assign m_axi_araddr  = cur_addr;
    assign m_axi_arsize  = 3'(SZ);
    assign m_axi_arburst = 2'b01;
    assign fifo_wdata    = m_axi_rdata;

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        m_axi_arvalid = 1'b0;
        m_axi_arlen   = 8'd0;
        m_axi_rready  = 1'b0;
        fifo_wr       = 1'b0;
        case (state)
            S_IDLE: begin
                if (kick) begin
                    state_nxt = (read_num == '0) ? S_DONE : S_ADDR;
                end
            end
            S_ADDR: begin
                m_axi_arvalid = 1'b1;
                m_axi_arlen   = 8'(len - 9'd1);
                if (m_axi_arready) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                m_axi_rready = !fifo_full;
                fifo_wr      = beat;
                if (burst_end) begin
                    state_nxt = (remain == NUM_WIDTH'(len)) ? S_DONE : S_ADDR;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr <= 32'd0;
            remain   <= '0;
            beat_cnt <= 9'd0;
            busy     <= 1'b0;
        end else begin
            busy <= (state_nxt != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (kick) begin
                        cur_addr <= read_addr & ADDR_MASK;
                        remain   <= read_num;
                        beat_cnt <= 9'd0;
                    end
                end
                S_DATA: begin
                    if (beat) begin
                        if (last_cnt) begin
                            beat_cnt <= 9'd0;
                            remain   <= remain - NUM_WIDTH'(len);
                            cur_addr <= cur_addr + (32'(len) << SZ);
                        end else begin
                            beat_cnt <= beat_cnt + 9'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef HDMI_AXI_RD_ERRCHK_EN
    logic beat_bad;

    // rlast is only cross-checked against the counter; the counter alone
    // decides where the burst ends.
    assign beat_bad = (m_axi_rresp != 2'b00) || (m_axi_rlast != last_cnt);

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            rd_err     <= 1'b0;
            rd_err_cnt <= 8'd0;
        end else if (beat && beat_bad) begin
            rd_err <= 1'b1;
            if (rd_err_cnt != 8'hFF) begin
                rd_err_cnt <= rd_err_cnt + 8'd1;
            end
        end
    end
`else
    logic unused_err_inputs;

    assign unused_err_inputs = ^{m_axi_rresp, m_axi_rlast};
    assign rd_err            = 1'b0;
    assign rd_err_cnt        = 8'd0;
`endif

endmodule

// File: tb/tb_hdmi_axi_rd_master.sv
module tb_hdmi_axi_rd_master;

    logic        clk_vga = 1'b0;
    logic        rst_n   = 1'b0;
    logic        kick    = 1'b0;
    logic [31:0] read_addr = 32'd0;
    logic [15:0] read_num  = 16'd0;
    logic        busy;

    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b1;

    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    logic        fifo_wr;
    logic [31:0] fifo_wdata;
    logic        fifo_full = 1'b0;

    logic        rd_err;
    logic [7:0]  rd_err_cnt;

    int passed = 0;
    int total  = 0;

    // Slave model state (written only by the slave process)
    int          pend   = 0;
    logic [31:0] s_addr = 32'd0;
    logic        err_on = 1'b0;

    logic [31:0] ar_addr_q [$];
    logic [7:0]  ar_len_q  [$];
    logic [31:0] wr_q      [$];

`ifdef HDMI_AXI_RD_ERRCHK_EN
    localparam logic       EXP_ERR     = 1'b1;
    localparam logic [7:0] EXP_ERR_CNT = 8'd3;
`else
    localparam logic       EXP_ERR     = 1'b0;
    localparam logic [7:0] EXP_ERR_CNT = 8'd0;
`endif

    hdmi_axi_rd_master #(
        .DATA_WIDTH (32),
        .BURST_LEN  (16),
        .NUM_WIDTH  (16)
    ) dut (
        .clk_vga       (clk_vga),
        .rst_n         (rst_n),
        .kick          (kick),
        .read_addr     (read_addr),
        .read_num      (read_num),
        .busy          (busy),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .fifo_wr       (fifo_wr),
        .fifo_wdata    (fifo_wdata),
        .fifo_full     (fifo_full),
        .rd_err        (rd_err),
        .rd_err_cnt    (rd_err_cnt)
    );

    always #5 clk_vga = ~clk_vga;

    // Memory returns the word address as data, so ordering is easy to check.
    assign m_axi_rvalid = (pend > 0);
    assign m_axi_rdata  = s_addr >> 2;
    assign m_axi_rlast  = (pend == 1);
    assign m_axi_rresp  = (err_on && (((s_addr >> 2) & 32'd7) < 32'd3)) ? 2'b10 : 2'b00;

    always @(posedge clk_vga) begin
        logic        hs_ar;
        logic        hs_r;
        logic [31:0] a;
        logic [7:0]  l;
        hs_ar = m_axi_arvalid && m_axi_arready;
        hs_r  = m_axi_rvalid && m_axi_rready;
        a     = m_axi_araddr;
        l     = m_axi_arlen;
        #1;
        if (!rst_n) begin
            pend = 0;
        end else begin
            if (hs_r) begin
                pend   = pend - 1;
                s_addr = s_addr + 32'd4;
            end
            if (hs_ar) begin
                pend   = int'(l) + 1;
                s_addr = a;
            end
        end
    end

    always @(posedge clk_vga) begin
        if (m_axi_arvalid && m_axi_arready) begin
            ar_addr_q.push_back(m_axi_araddr);
            ar_len_q.push_back(m_axi_arlen);
        end
        if (fifo_wr) begin
            wr_q.push_back(fifo_wdata);
        end
    end

    task automatic tick;
        @(posedge clk_vga);
        #2;
    endtask

    task automatic start_fetch(input logic [31:0] addr, input logic [15:0] num);
        read_addr = addr;
        read_num  = num;
        kick      = 1'b1;
        tick;
        kick      = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            tick;
            n++;
        end
        total++;
        if (busy !== 1'b0) $display("FAIL %s_timeout: busy=%0b after %0d cycles, want 0", name, busy, n);
        else passed++;
    endtask

    task automatic check_fetch(input string name, input int ab, input int wb,
                               input int n_ar, input logic [31:0] a0,
                               input logic [31:0] n_beats);
        int          errs;
        int          remaining;
        logic [31:0] a;
        logic [31:0] bnd;
        logic [31:0] l;
        total++;
        if (ar_addr_q.size() - ab !== n_ar)
            $display("FAIL %s_ar_count: got %0d want %0d", name, ar_addr_q.size() - ab, n_ar);
        else passed++;
        errs = 0;
        a = a0;
        remaining = int'(n_beats);
        for (int i = 0; i < n_ar; i++) begin
            bnd = (32'h1000 - {20'd0, a[11:0]}) >> 2;
            l   = 32'(remaining);
            if (l > 32'd16) l = 32'd16;
            if (l > bnd)    l = bnd;
            if (ab + i >= ar_addr_q.size()) errs++;
            else if (ar_addr_q[ab+i] !== a || ar_len_q[ab+i] !== 8'(l - 32'd1)) errs++;
            a = a + (l << 2);
            remaining = remaining - int'(l);
        end
        total++;
        if (errs !== 0) $display("FAIL %s_ar_fields: %0d bad AR entries, want 0", name, errs);
        else passed++;
        total++;
        if (wr_q.size() - wb !== int'(n_beats))
            $display("FAIL %s_wr_count: got %0d want %0d", name, wr_q.size() - wb, n_beats);
        else passed++;
        errs = 0;
        for (int i = 0; i < int'(n_beats); i++) begin
            if (wb + i >= wr_q.size()) errs++;
            else if (wr_q[wb+i] !== (a0 >> 2) + 32'(i)) errs++;
        end
        total++;
        if (errs !== 0) $display("FAIL %s_data_order: %0d bad beats, want 0", name, errs);
        else passed++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        total++;
        if ({busy, m_axi_arvalid, m_axi_rready, fifo_wr} !== 4'b0000)
            $display("FAIL reset_ctrl: busy/arvalid/rready/fifo_wr=%b want 0000",
                     {busy, m_axi_arvalid, m_axi_rready, fifo_wr});
        else passed++;
        total++;
        if (m_axi_araddr !== 32'd0 || m_axi_arlen !== 8'd0)
            $display("FAIL reset_ar: araddr=%h arlen=%0d want 0/0", m_axi_araddr, m_axi_arlen);
        else passed++;
        total++;
        if (m_axi_arsize !== 3'd2 || m_axi_arburst !== 2'b01)
            $display("FAIL reset_const: arsize=%0d arburst=%b want 2/01", m_axi_arsize, m_axi_arburst);
        else passed++;
        total++;
        if (rd_err !== 1'b0 || rd_err_cnt !== 8'd0)
            $display("FAIL reset_err: rd_err=%0b cnt=%0d want 0/0", rd_err, rd_err_cnt);
        else passed++;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_single;
        int ab, wb, n, last;
        ab = ar_addr_q.size();
        wb = wr_q.size();
        start_fetch(32'h1000, 16'd8);
        total++;
        if (busy !== 1'b1 || m_axi_arvalid !== 1'b1)
            $display("FAIL single_start: busy=%0b arvalid=%0b want 1/1", busy, m_axi_arvalid);
        else passed++;
        total++;
        if (m_axi_araddr !== 32'h1000 || m_axi_arlen !== 8'd7)
            $display("FAIL single_ar: araddr=%h arlen=%0d want 1000/7", m_axi_araddr, m_axi_arlen);
        else passed++;
        n = 0;
        last = -100;
        while (busy && n < 200) begin
            if (fifo_wr) last = n;
            tick;
            n++;
        end
        total++;
        if (busy !== 1'b0 || n - last !== 2)
            $display("FAIL single_busy_fall: busy=%0b cycles_after_last_beat=%0d want 0/2", busy, n - last);
        else passed++;
        check_fetch("single", ab, wb, 1, 32'h1000, 32'd8);
    endtask

    task automatic test_multi_burst;
        int ab, wb;
        ab = ar_addr_q.size();
        wb = wr_q.size();
        start_fetch(32'h1000, 16'd256);
        wait_idle("multi", 800);
        check_fetch("multi", ab, wb, 16, 32'h1000, 32'd256);
    endtask

    task automatic test_4k_split;
        int ab, wb;
        ab = ar_addr_q.size();
        wb = wr_q.size();
        start_fetch(32'h0FF0, 16'd16);
        wait_idle("split", 200);
        check_fetch("split", ab, wb, 2, 32'h0FF0, 32'd16);
        total++;
        if (ar_len_q.size() < ab + 2 || ar_len_q[ab] !== 8'd3 || ar_len_q[ab+1] !== 8'd11)
            $display("FAIL split_lens: got %0d/%0d want 3/11",
                     (ar_len_q.size() > ab) ? ar_len_q[ab] : 8'hxx,
                     (ar_len_q.size() > ab + 1) ? ar_len_q[ab+1] : 8'hxx);
        else passed++;
    endtask

    task automatic test_backpressure;
        int ab, wb, n, viol;
        ab = ar_addr_q.size();
        wb = wr_q.size();
        start_fetch(32'h2000, 16'd40);
        n = 0;
        viol = 0;
        while (busy && n < 600) begin
            fifo_full = (((n / 3) % 2) == 1);
            #1;
            if (fifo_full && (m_axi_rready || fifo_wr)) viol++;
            if (m_axi_rvalid && (m_axi_rready !== !fifo_full)) viol++;
            tick;
            n++;
        end
        fifo_full = 1'b0;
        total++;
        if (busy !== 1'b0) $display("FAIL bp_timeout: busy=%0b after %0d cycles, want 0", busy, n);
        else passed++;
        total++;
        if (viol !== 0) $display("FAIL bp_rready: %0d cycles with rready/fifo_wr wrong, want 0", viol);
        else passed++;
        check_fetch("bp", ab, wb, 3, 32'h2000, 32'd40);
    endtask

    task automatic test_kick_while_busy;
        int ab, wb;
        ab = ar_addr_q.size();
        wb = wr_q.size();
        start_fetch(32'h3000, 16'd32);
        tick;
        tick;
        tick;
        read_addr = 32'h5000;
        read_num  = 16'd16;
        kick      = 1'b1;
        tick;
        kick      = 1'b0;
        wait_idle("kickbusy", 300);
        for (int i = 0; i < 5; i++) tick;
        total++;
        if (busy !== 1'b0) $display("FAIL kickbusy_idle: busy=%0b want 0", busy);
        else passed++;
        check_fetch("kickbusy", ab, wb, 2, 32'h3000, 32'd32);
    endtask

    task automatic test_zero_length;
        int ab;
        ab = ar_addr_q.size();
        start_fetch(32'h4000, 16'd0);
        total++;
        if (busy !== 1'b1 || m_axi_arvalid !== 1'b0)
            $display("FAIL zero_first: busy=%0b arvalid=%0b want 1/0", busy, m_axi_arvalid);
        else passed++;
        tick;
        total++;
        if (busy !== 1'b0 || m_axi_arvalid !== 1'b0)
            $display("FAIL zero_second: busy=%0b arvalid=%0b want 0/0", busy, m_axi_arvalid);
        else passed++;
        tick;
        total++;
        if (ar_addr_q.size() - ab !== 0)
            $display("FAIL zero_no_ar: got %0d ARs want 0", ar_addr_q.size() - ab);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int ab, wb;
        start_fetch(32'h1000, 16'd64);
        for (int i = 0; i < 6; i++) tick;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, m_axi_arvalid, m_axi_rready, fifo_wr} !== 4'b0000)
            $display("FAIL rstmid_ctrl: busy/arvalid/rready/fifo_wr=%b want 0000",
                     {busy, m_axi_arvalid, m_axi_rready, fifo_wr});
        else passed++;
        total++;
        if (m_axi_araddr !== 32'd0 || m_axi_arlen !== 8'd0)
            $display("FAIL rstmid_ar: araddr=%h arlen=%0d want 0/0", m_axi_araddr, m_axi_arlen);
        else passed++;
        tick;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        ab = ar_addr_q.size();
        wb = wr_q.size();
        start_fetch(32'h1000, 16'd8);
        wait_idle("rstmid", 200);
        check_fetch("rstmid", ab, wb, 1, 32'h1000, 32'd8);
    endtask

    task automatic test_errors;
        int wb;
        wb = wr_q.size();
        err_on = 1'b1;
        start_fetch(32'h1000, 16'd8);
        wait_idle("err", 200);
        err_on = 1'b0;
        total++;
        if (rd_err !== EXP_ERR || rd_err_cnt !== EXP_ERR_CNT)
            $display("FAIL err_count: rd_err=%0b cnt=%0d want %0b/%0d", rd_err, rd_err_cnt, EXP_ERR, EXP_ERR_CNT);
        else passed++;
        total++;
        if (wr_q.size() - wb !== 8)
            $display("FAIL err_writes: got %0d want 8", wr_q.size() - wb);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_single;
        test_multi_burst;
        test_4k_split;
        test_backpressure;
        test_kick_while_busy;
        test_zero_length;
        test_reset_mid;
        test_errors;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hdmi_axi_rd_master.md
# hdmi_axi_rd_master

Downstream stage of `hdmi_axi_addr`: accepts a line-fetch request (`kick`, `read_addr`, `read_num`) and turns it into a sequence of AXI4 INCR read bursts. It streams returned pixel beats into the HDMI line FIFO. `busy` back to the address generator covers the whole fetch. The block runs entirely in the pixel clock domain, with one burst outstanding at a time.

## Interface
- `DATA_WIDTH`, 32: AXI data width and pixel-beat width; legal values 32, 64, 128.
- `BURST_LEN`, 16: maximum beats per burst; power of two, 1..256.
- `NUM_WIDTH`, 16: width of `read_num`.
- `clk_vga` input 1: pixel clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `kick` input 1: fetch request; sampled in IDLE only.
- `read_addr` input 32: byte start address. Low log2(DATA_WIDTH/8) bits are ignored.
- `read_num` input NUM_WIDTH: number of beats to fetch.
- `busy` output 1: fetch in progress.
- `m_axi_araddr` output 32, `m_axi_arlen` output 8, `m_axi_arsize` output 3, `m_axi_arburst` output 2, `m_axi_arvalid` output 1, `m_axi_arready` input 1: AXI4 read address channel.
- `m_axi_rdata` input DATA_WIDTH, `m_axi_rresp` input 2, `m_axi_rlast` input 1, `m_axi_rvalid` input 1, `m_axi_rready` output 1: AXI4 read data channel.
- `fifo_wr` output 1, `fifo_wdata` output DATA_WIDTH, `fifo_full` input 1: line FIFO write port. `fifo_full` must be a full flag with zero-cycle response.
- `rd_err` output 1, `rd_err_cnt` output 8: error reporting (see Configuration).

## Operation
- FSM states: IDLE, ADDR, DATA, DONE.
- **IDLE**
  - On `kick`=1: latch the aligned address into `cur_addr` and `read_num` into `remain`.
  - If `read_num`=0, go to DONE; otherwise go to ADDR.
  - A `kick` received in any other state is ignored (not queued).
- **ADDR**
  - `len` = min(`remain`, BURST_LEN, beats remaining to the next 4 KiB boundary from `cur_addr`).
  - Drive `arvalid`=1, `araddr`=`cur_addr`, `arlen`=`len`-1, `arsize`=log2(DATA_WIDTH/8), `arburst`=2'b01.
  - AR outputs stay stable until `arvalid`&&`arready`; then go to DATA.
- **DATA**
  - `rready` = !`fifo_full`.
  - Each beat with `rvalid`&&`rready` produces `fifo_wr`=1 and `fifo_wdata`=`rdata`, same cycle (combinational).
  - A beat counter ends the burst after `len` accepted beats. `rlast` is not used for control.
  - At burst end: `remain` -= `len`, `cur_addr` += `len`*DATA_WIDTH/8. If `remain`=0, go to DONE; otherwise go to ADDR.
- **DONE**: one cycle, then IDLE.
- `busy` = (state != IDLE), registered.
- Address arithmetic wraps modulo 2^32. `remain` never underflows because `len` ≤ `remain`.

## Timing
- Reset values: `busy`=0, `arvalid`=0, `araddr`=0, `arlen`=0, `arsize`=log2(DATA_WIDTH/8), `arburst`=2'b01, `rready`=0, `fifo_wr`=0, `rd_err`=0, `rd_err_cnt`=0. State resets to IDLE.
- Reset asserted mid-fetch clears everything immediately; the AXI interconnect is reset by the same `rst_n`.
- Cycle timing from `kick` (edge N):
  - `busy`=1 and `arvalid`=1 from edge N+1.
  - First AR handshake is possible at edge N+1.
  - `rready` is valid from the cycle after the AR handshake.
- Gap between bursts: 1 cycle (DATA→ADDR) before the next `arvalid`.
- After the final beat, DONE lasts 1 cycle and `busy` falls 2 edges after the last beat.
- Zero-length request: `busy` high for exactly 1 cycle, no AR issued.
- When `fifo_full` and `rvalid` are both high in the same cycle, no transfer occurs and `fifo_wr`=0.

## Configuration
- Macro: `HDMI_AXI_RD_ERRCHK_EN`.
- **Defined**:
  - Any accepted beat with `rresp`≠2'b00 sets `rd_err` (sticky until reset) and increments `rd_err_cnt`, saturating at 255.
  - An `rlast` value on the counted final beat that disagrees with the counter also counts as an error.
  - Data is still written to the FIFO in both cases.
- **Undefined**: `rd_err` and `rd_err_cnt` are tied to 0, and `rresp`/`rlast` are unused.

## Test plan
- **Single short fetch**: kick with addr=0x1000, num=8, DATA_WIDTH=32, arready always 1 → one AR with araddr=0x1000, arlen=7; 8 `fifo_wr` pulses; `busy` falls 2 cycles after the last beat.
- **Multi-burst line**: num=256, BURST_LEN=16 → 16 ARs at 0x1000, 0x1040, …, 0x13C0, each with arlen=15; 256 FIFO writes with data order preserved.
- **4 KiB split**: addr=0x0FF0, num=16 → AR at 0x0FF0 with arlen=3, then AR at 0x1000 with arlen=11.
- **Backpressure**: `fifo_full` toggled every 3 cycles with rvalid held high → `rready` mirrors !`fifo_full`; no beat lost or duplicated; total writes equal num.
- **Kick while busy and zero length**:
  - A second kick during a fetch is ignored, with exactly one fetch's worth of ARs.
  - num=0 → 1-cycle `busy`, no `arvalid`.
- **Reset and error counting**:
  - `rst_n` low mid-burst → all outputs at reset values immediately, and the next kick runs cleanly.
  - With the macro defined, 3 beats with rresp=2'b10 → `rd_err`=1, `rd_err_cnt`=3.
